led_fader: RTL and testbench
============================

LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter CLK_FREQ, 25_000_000, system clock frequency in Hz.
REQ-002 Parameter NUM_LEDS, 8, number of LED channels (>=2).
REQ-003 Parameter PWM_BITS, 8, PWM resolution; PWM_MAX = 2^PWM_BITS-1.
REQ-004 Parameter STEP_CYCLES, CLK_FREQ/1000, clocks per fade step tick (>=1).
REQ-005 Parameter HOLD_STEPS, 0, ticks spent at full level before swap.
REQ-006 clk  input  1  single system clock, rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 enable  input  1  run when high; freeze and blank when low.
REQ-009 mode  input  2  00 crossfade, 01 breathe, 10 blink, 11 chase.
REQ-010 leds  output  NUM_LEDS  registered PWM outputs.
REQ-011 cycle_done  output  1  one-clock pulse per completed fade cycle.

Function
REQ-012 PWM counter (PWM_BITS) SHALL increment every enabled clock and wrap PWM_MAX->0.
REQ-013 Prescaler SHALL count 0..STEP_CYCLES-1 while enabled, asserting tick on STEP_CYCLES-1 and wrapping to 0; width max(1,clog2(STEP_CYCLES)).
REQ-014 leds[i] SHALL be registered: 1 when duty_i==PWM_MAX, else (pwm_cnt < duty_i); 1-clock latency from counter/duty.
REQ-015 FSM states RAMP, HOLD, SWAP; RAMP: lvl+=1 per tick; tick with lvl==PWM_MAX-1 sets lvl=PWM_MAX and moves to HOLD.
REQ-016 HOLD SHALL exit to SWAP on its HOLD_STEPS-th tick; HOLD_STEPS==0 exits on the next clock.
REQ-017 SWAP SHALL last one clock: lvl<=0, mask updated, cycle_done=1, next state RAMP.
REQ-018 Mode 00: mask bit 1 -> duty PWM_MAX-lvl; mask bit 0 -> duty lvl; SWAP inverts mask.
REQ-019 Mode 01: all LEDs duty = mask[0] ? PWM_MAX-lvl : lvl; SWAP inverts mask.
REQ-020 Mode 10: mask bit 1 -> duty PWM_MAX, mask bit 0 -> duty 0; SWAP inverts mask.
REQ-021 Mode 11: mask one-hot; LED at mask duty PWM_MAX-lvl, LED at rotate-left(mask) duty lvl, others 0; SWAP rotates mask left by 1, wrapping MSB->LSB.
REQ-022 Mode SHALL be registered (mode_q); a change SHALL, next clock, force RAMP, lvl=0, prescaler=0, and reload mask (alternating 0101.. with bit0=1 for modes 00-10, one-hot bit0 for 11); no cycle_done.
REQ-023 enable low SHALL freeze state, lvl, mask, prescaler, PWM counter; leds SHALL be 0 from the next clock; cycle_done 0; re-assert resumes from frozen values.
REQ-024 Simultaneous mode change and enable low: mode reload SHALL take priority, values then frozen.
REQ-025 lvl arithmetic SHALL be unsigned PWM_BITS, never exceeding PWM_MAX nor wrapping.

Reset
REQ-026 rst high SHALL immediately force leds=0, cycle_done=0, lvl=0, pwm/prescaler=0, state RAMP, mode_q=00, mask=alternating with bit0=1.
REQ-027 rst asserted mid-cycle SHALL discard all progress; release restarts at RAMP lvl 0.

Structure
REQ-028 Package led_fader_pkg SHALL hold mode encodings and FSM state encodings.
REQ-029 Sub-module pwm_channel (registered comparator with full-on override) SHALL be instantiated NUM_LEDS times.

Verification (NUM_LEDS=4, PWM_BITS=3, STEP_CYCLES=2, HOLD_STEPS=0)
REQ-030 rst pulsed mid-ramp -> leds=0000, cycle_done=0 same cycle; lvl=0, mask=0101 after release.
REQ-031 Mode 00, lvl=2 over one 8-clock PWM period -> leds[0],[2] high 5 clocks, leds[1],[3] high 2 clocks.
REQ-032 Mode 00 at lvl=7 -> leds[1],[3] constantly 1, leds[0],[2] constantly 0 for full period.
REQ-033 Mode 00 from reset -> cycle_done pulses once 16 clocks after reset release (7 ticks, HOLD, SWAP); mask 1010 afterwards.
REQ-034 Mode 11 -> mask 0001->0010->0100->1000->0001 across 4 cycle_done pulses.
REQ-035 enable low 10 clocks at lvl=3 -> leds 0000, lvl stays 3; mode change mid-ramp -> lvl 0, mask reloaded, no cycle_done.

Source files
------------

// File: rtl/led_fader_pkg.sv
// Shared encodings for the LED fader: pattern modes and fade sequencer states.
package led_fader_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_XFADE   = 2'b00,
    MODE_BREATHE = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_CHASE   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_RAMP = 2'b00,
    ST_HOLD = 2'b01,
    ST_SWAP = 2'b10
  } state_e;

  function automatic logic is_chase(input mode_e m);
    return (m == MODE_CHASE);
  endfunction

endpackage

// File: rtl/led_fader_pwm_channel.sv
// One LED output: registered PWM comparator with a full-on override at maximum duty.
module pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

  logic led_p1;

  // p1: compare stage; full duty must stay lit through the counter's PWM_MAX slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_p1 <= 1'b0;
    end else begin
      led_p1 <= enable & ((duty == PWM_MAX) | (pwm_cnt < duty));
    end
  end

  assign led = led_p1;

endmodule

// File: rtl/led_fader.sv
// Multi-channel LED fader: prescaled fade level sequencer driving per-LED PWM channels.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int CLK_FREQ    = 25_000_000,
  parameter int NUM_LEDS    = 8,
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = CLK_FREQ / 1000,
  parameter int HOLD_STEPS  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] leds,
  output logic                cycle_done
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};
  localparam int PS_W      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HOLD_W    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam int HOLD_LAST = (HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0;

  mode_e                mode_q;
  state_e               state, state_nxt;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [PS_W-1:0]      presc;
  logic                 tick;
  logic                 mode_chg;
  logic [PWM_BITS-1:0]  lvl, lvl_nxt;
  logic [NUM_LEDS-1:0]  mask, mask_nxt, mask_rot;
  logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic                 done_nxt;
  logic [PWM_BITS-1:0]  duty_p0 [NUM_LEDS];

  function automatic logic [NUM_LEDS-1:0] reload_mask(input mode_e m);
    logic [NUM_LEDS-1:0] r;
    r = '0;
    if (is_chase(m)) begin
      r[0] = 1'b1;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) r[i] = ((i % 2) == 0);
    end
    return r;
  endfunction

  function automatic logic [NUM_LEDS-1:0] swap_mask(input logic [NUM_LEDS-1:0] m,
                                                    input mode_e md);
    return is_chase(md) ? {m[NUM_LEDS-2:0], m[NUM_LEDS-1]} : ~m;
  endfunction

  // Saturating step so the level can never wrap past full brightness
  function automatic logic [PWM_BITS-1:0] lvl_inc(input logic [PWM_BITS-1:0] v);
    return (v == PWM_MAX) ? PWM_MAX : v + 1'b1;
  endfunction

  assign mode_chg = (mode_e'(mode) != mode_q);
  assign tick     = (presc == PS_W'(STEP_CYCLES - 1));
  assign mask_rot = {mask[NUM_LEDS-2:0], mask[NUM_LEDS-1]};

  // A mode change restarts the step timebase even while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_XFADE;
      pwm_cnt <= '0;
      presc   <= '0;
    end else begin
      mode_q <= mode_e'(mode);
      if (enable) pwm_cnt <= pwm_cnt + 1'b1;
      if (mode_chg) begin
        presc <= '0;
      end else if (enable) begin
        presc <= tick ? '0 : presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RAMP;
      lvl        <= '0;
      mask       <= reload_mask(MODE_XFADE);
      hold_cnt   <= '0;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      lvl        <= lvl_nxt;
      mask       <= mask_nxt;
      hold_cnt   <= hold_nxt;
      cycle_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lvl_nxt   = lvl;
    mask_nxt  = mask;
    hold_nxt  = hold_cnt;
    done_nxt  = 1'b0;
    if (mode_chg) begin
      state_nxt = ST_RAMP;
      lvl_nxt   = '0;
      mask_nxt  = reload_mask(mode_e'(mode));
      hold_nxt  = '0;
    end else if (enable) begin
      case (state)
        ST_RAMP: begin
          if (tick) begin
            if (lvl >= PWM_MAX - 1'b1) begin
              lvl_nxt   = PWM_MAX;
              state_nxt = ST_HOLD;
              hold_nxt  = '0;
            end else begin
              lvl_nxt = lvl_inc(lvl);
            end
          end
        end
        ST_HOLD: begin
          if (HOLD_STEPS == 0) begin
            state_nxt = ST_SWAP;
          end else if (tick) begin
            if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
              state_nxt = ST_SWAP;
            end else begin
              hold_nxt = hold_cnt + 1'b1;
            end
          end
        end
        ST_SWAP: begin
          lvl_nxt   = '0;
          mask_nxt  = swap_mask(mask, mode_q);
          done_nxt  = 1'b1;
          state_nxt = ST_RAMP;
        end
        default: begin
          state_nxt = ST_RAMP;
          lvl_nxt   = '0;
        end
      endcase
    end
  end

  // p0: per-LED duty from the current level, mask and registered mode
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      duty_p0[i] = '0;
      case (mode_q)
        MODE_XFADE:   duty_p0[i] = mask[i] ? (PWM_MAX - lvl) : lvl;
        MODE_BREATHE: duty_p0[i] = mask[0] ? (PWM_MAX - lvl) : lvl;
        MODE_BLINK:   duty_p0[i] = mask[i] ? PWM_MAX : '0;
        MODE_CHASE: begin
          if (mask[i]) begin
            duty_p0[i] = PWM_MAX - lvl;
          end else if (mask_rot[i]) begin
            duty_p0[i] = lvl;
          end
        end
        default: duty_p0[i] = '0;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .pwm_cnt(pwm_cnt),
      .duty   (duty_p0[g]),
      .led    (leds[g])
    );
  end

endmodule

// File: tb/tb_led_fader.sv
// Randomized bench for led_fader with an in-bench behavioural reference model.
module tb_led_fader;

  localparam int NL   = 4;
  localparam int PMAX = 7;
  localparam int STEP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic [NL-1:0] leds;
  logic          cycle_done;

  int n_vec = 0;
  int n_err = 0;

  // reference model state (phase: 0 ramping, 1 holding at full, 2 swapping)
  int m_pwm, m_presc, m_lvl, m_phase, m_mask, m_mode;
  int exp_leds, exp_cd;

  led_fader #(
    .CLK_FREQ   (25_000_000),
    .NUM_LEDS   (NL),
    .PWM_BITS   (3),
    .STEP_CYCLES(STEP),
    .HOLD_STEPS (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .mode      (mode),
    .leds      (leds),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int alt_mask();
    int r = 0;
    for (int i = 0; i < NL; i += 2) r |= (1 << i);
    return r;
  endfunction

  function automatic int duty_of(input int i);
    int idx = 0;
    case (m_mode)
      0: return ((m_mask >> i) & 1) ? PMAX - m_lvl : m_lvl;
      1: return (m_mask & 1) ? PMAX - m_lvl : m_lvl;
      2: return ((m_mask >> i) & 1) ? PMAX : 0;
      default: begin
        for (int j = 0; j < NL; j++) if ((m_mask >> j) & 1) idx = j;
        if (i == idx) return PMAX - m_lvl;
        if (i == (idx + 1) % NL) return m_lvl;
        return 0;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_pwm = 0; m_presc = 0; m_lvl = 0; m_phase = 0;
    m_mode = 0; m_mask = alt_mask();
    exp_leds = 0; exp_cd = 0;
  endtask

  task automatic model_edge();
    int  nl, d;
    bit  chg, tick;
    if (rst) begin
      model_reset();
      return;
    end
    chg = (int'(mode) != m_mode);
    nl = 0;
    for (int i = 0; i < NL; i++) begin
      d = duty_of(i);
      if (enable && (d == PMAX || m_pwm < d)) nl |= (1 << i);
    end
    exp_leds = nl;
    exp_cd   = (enable && !chg && m_phase == 2) ? 1 : 0;
    if (enable) m_pwm = (m_pwm + 1) % (PMAX + 1);
    if (chg) begin
      m_mode = int'(mode); m_lvl = 0; m_presc = 0; m_phase = 0;
      m_mask = (m_mode == 3) ? 1 : alt_mask();
    end else if (enable) begin
      tick = (m_presc == STEP - 1);
      m_presc = tick ? 0 : m_presc + 1;
      case (m_phase)
        0: if (tick) begin
             m_lvl = m_lvl + 1;
             if (m_lvl == PMAX) m_phase = 1;
           end
        1: m_phase = 2;
        default: begin
          m_lvl = 0; m_phase = 0;
          if (m_mode == 3) m_mask = ((m_mask << 1) | (m_mask >> (NL - 1))) & ((1 << NL) - 1);
          else m_mask = ~m_mask & ((1 << NL) - 1);
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("leds", int'(leds), exp_leds);
    chk("cycle_done", int'(cycle_done), exp_cd);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_leds_async", int'(leds), 0);
    chk("rst_done_async", int'(cycle_done), 0);
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int  n;
    bit  seen;
    int  chase_exp [4] = '{2, 4, 8, 1};
    model_reset();
    step();
    step();
    chk("reset_leds", int'(leds), 0);

    // first fade cycle latency from reset release, and mask afterwards
    rst = 1'b0;
    n = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      n++;
      if (cycle_done) seen = 1;
    end
    chk("done_latency", n, 16);
    step();
    chk("mask_after_swap", int'(leds), 4'b1010);

    // reset in the middle of a ramp
    for (int k = 0; k < 5; k++) step();
    pulse_reset();
    step();
    chk("mask_after_rst", int'(leds), 4'b0101);

    // freeze at level 3, then resume
    for (int k = 0; k < 40 && m_lvl != 3; k++) step();
    chk("reach_lvl3", m_lvl, 3);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("blank", int'(leds), 0);
    end
    enable = 1'b1;
    for (int k = 0; k < 6; k++) step();

    // mode change mid-ramp
    mode = 2'b01;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no_done_on_mode", int'(cycle_done), 0);
    end
    for (int k = 0; k < 40; k++) step();

    // chase rotation across four cycles
    mode = 2'b11;
    step();
    for (int p = 0; p < 4; p++) begin
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
        step();
        if (cycle_done) seen = 1;
      end
      chk("chase_done_seen", int'(seen), 1);
      step();
      chk("chase_mask", int'(leds), chase_exp[p]);
    end

    // blink for a while
    mode = 2'b10;
    for (int k = 0; k < 40; k++) step();

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
